if_fetch_buf: RTL and testbench
===============================

# if_fetch_buf

Instruction fetch buffer sitting directly downstream of the PC stage and its synchronous instruction ROM, and directly upstream of decode. Each cycle the PC stage asserts `ce` with an address. The block delays that request by one cycle to line it up with the ROM's registered read data, then pushes the {pc, inst} pair into a small FIFO. Decode drains the FIFO through a valid/ready handshake, and the block tells the PC stage when to stop issuing through `hold`.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2
- `ADDR_W`, 16 — PC / ROM address width
- `INST_W`, 32 — instruction width

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `ce`  in  1  — fetch request from the PC stage; a ROM read is in flight for `pc` this cycle
- `pc`  in  ADDR_W  — address presented to the ROM this cycle
- `inst`  in  INST_W  — ROM read data; valid the cycle after the matching `ce`/`pc`
- `flush`  in  1  — discard all buffered and in-flight fetches (branch/redirect)
- `hold`  out  1  — PC stage must keep `ce`=0 while high
- `out_valid`  out  1  — FIFO head is valid
- `out_pc`  out  ADDR_W  — PC of the head entry
- `out_inst`  out  INST_W  — instruction of the head entry
- `out_ready`  in  1  — decode accepts the head this cycle
- `ovf`  out  1  — sticky error: a push arrived while the FIFO was full

## Operation
- Request pipe registers: `ce_d` ← `ce`, `pc_d` ← `pc` every cycle.
- Push condition: `ce_d`=1 and `flush`=0. The pushed entry is {`pc_d`, `inst`}.
- Pop condition: `out_valid`=1, `out_ready`=1 and `flush`=0.
- Push and pop in the same cycle: count is unchanged. This is legal when full (pop frees the slot) and when empty with count>0 impossible; a push into an empty FIFO is not forwarded in the same cycle.
- `out_valid` = (count != 0). `out_pc`/`out_inst` are the head storage entry, with no combinational path from `inst`.
- `hold` = (count + `ce_d`) ≥ DEPTH. It is combinational from registered state only and ignores a pending pop, so it is conservative. Honouring `hold` guarantees there is a slot for every in-flight read.
- Push with count==DEPTH and no simultaneous pop: the entry is dropped, `ovf` is set, and `ovf` stays set until reset.
- `flush`: next state has count=0, read/write pointers 0 and `ce_d`=0, so the read returning next cycle is squashed. `flush` overrides push and pop in the same cycle. `pc`/`ce` presented during the flush cycle are also squashed through the cleared `ce_d`.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values (asynchronous, while `rst`=0): `ce_d`=0, `pc_d`=0, pointers 0, count 0, all storage 0, `out_valid`=0, `out_pc`=0, `out_inst`=0, `hold`=0, `ovf`=0.
- Latency: `ce` at cycle n → ROM data at n+1 → pushed at the end of n+1 → `out_valid` at n+2.
- Sustained throughput is 1 instruction/cycle when `out_ready` stays high.
- Reset asserted mid-operation clears all state immediately. Deassertion takes effect at the next `clk` edge.

## Structure
- Shared defines package holds `ADDR_W`/`INST_W` defaults and a `fetch_entry_t` packed struct {pc, inst}.
- One natural sub-module: `if_fifo`, a generic synchronous FIFO parameterised on entry type and DEPTH. It has push/pop/flush inputs, count/full/empty outputs and async active-low reset.
- `if_fetch_buf` contains only the request pipe registers, the hold logic, the flush gating and `ovf`.

## Test plan
- Reset then stream: `ce`=1 with pc 0,1,2,… and `inst` = pc+0x100 one cycle later, `out_ready`=1. Required: `out_valid` rises 2 cycles after the first `ce`; outputs are (0,0x100),(1,0x101),… with no gaps; `hold` stays 0.
- Backpressure: `out_ready`=0 while streaming with `ce` gated by `hold`. Required: `hold` rises when count+`ce_d` reaches 4; the FIFO fills to exactly 4 entries in order; `ovf` stays 0. Releasing `out_ready` drains 4 entries in order and `hold` falls.
- Flush: with 3 entries queued and one read in flight, pulse `flush`. Required: `out_valid`=0 next cycle, the in-flight pair never appears, and fetch restarted at pc 0x40 emits 0x40 first.
- Full with simultaneous push/pop: FIFO at 4, `out_ready`=1, forced push. Required: count stays 4, order is preserved, `ovf`=0.
- Protocol violation: ignore `hold`, `out_ready`=0, push a 5th entry. Required: the entry is dropped, `ovf`=1 and stays 1 across a subsequent `flush`, and clears only on `rst`=0.
- Async reset mid-stream: drop `rst` between clock edges. Required: all outputs go to their reset values immediately, without waiting for a `clk` edge.

Source files
------------

// File: rtl/if_fetch_buf_pkg.sv
// Shared defaults and entry type for the instruction fetch buffer.
// Widths here are the defaults; if_fetch_buf rebuilds the entry type from its own parameters.
package if_fetch_buf_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_entry_t;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Generic synchronous FIFO: typed entries, power-of-two depth, flush to empty.
// Pointers wrap naturally; the count is one bit wider than the pointers.
module if_fifo
    import if_fetch_buf_pkg::*;
#(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  T                         wdata_i,
    output T                         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW:0]    count_q, count_d;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        full_o  = (count_q == (PW+1)'(DEPTH));
        empty_o = (count_q == '0);
        do_pop  = pop_i & ~empty_o & ~flush_i;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        do_push = push_i & (~full_o | do_pop) & ~flush_i;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_buf.sv
// Fetch buffer: aligns PC requests with registered ROM data and queues {pc, inst} for decode.
// Raises hold early enough that every in-flight ROM read is guaranteed a FIFO slot.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    input  logic              flush,
    output logic              hold,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic              ovf
);

    localparam int unsigned CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;

    logic              push;
    logic              pop;
    entry_t            wr_entry;
    entry_t            rd_entry;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [CW:0]       occupancy;

    always_comb begin
        // Clearing the request pipe on flush squashes the read that returns next cycle.
        ce_d      = ce & ~flush;
        pc_d      = pc;
        push      = ce_q & ~flush;
        pop       = ~empty & out_ready & ~flush;
        wr_entry  = '{pc: pc_q, inst: inst};
        ovf_d     = ovf_q | (push & full & ~pop);
        occupancy = (CW+1)'(count) + (CW+1)'(ce_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q  <= 1'b0;
            pc_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ce_q  <= ce_d;
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
        end
    end

    if_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign hold      = (occupancy >= (CW+1)'(DEPTH));
    assign out_valid = ~empty;
    assign out_pc    = rd_entry.pc;
    assign out_inst  = rd_entry.inst;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Self-checking bench for if_fetch_buf: queue-based reference model plus directed and random phases.
module tb_if_fetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [15:0] pc = '0;
    logic [31:0] inst = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        hold;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [31:0] out_inst;
    logic        ovf;

    always #5 clk = ~clk;

    if_fetch_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (16),
        .INST_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .pc        (pc),
        .inst      (inst),
        .flush     (flush),
        .hold      (hold),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    typedef struct {
        logic [15:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          ce_m = 1'b0;
    logic [15:0] pc_m = '0;
    bit          ovf_m = 1'b0;
    logic [15:0] last_pc = '0;
    logic [15:0] salt = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit hold_m();
        return (q.size() + int'(ce_m)) >= DEPTH;
    endfunction

    task automatic compare();
        chk("out_valid", out_valid, q.size() != 0);
        chk("hold", hold, hold_m());
        chk("ovf", ovf, ovf_m);
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, q[0].inst);
        end
    endtask

    task automatic model_step();
        ent_t e;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (ce_m) begin
                e.pc   = pc_m;
                e.inst = inst;
                if (q.size() < DEPTH) q.push_back(e);
                else ovf_m = 1'b1;
            end
        end
        ce_m = ce && !flush;
        pc_m = pc;
    endtask

    task automatic model_reset();
        q.delete();
        ce_m  = 1'b0;
        pc_m  = '0;
        ovf_m = 1'b0;
    endtask

    // Called at a negedge: check, drive this cycle's inputs, advance the model at the edge.
    task automatic cyc(input bit ce_v, input logic [15:0] pc_v, input bit fl, input bit rdy);
        compare();
        ce        = ce_v;
        pc        = pc_v;
        inst      = {salt, 16'h0} + 32'(last_pc) + 32'h100;
        last_pc   = pc_v;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_pc"}, out_pc, 16'h0);
        chk({tag, "_inst"}, out_inst, 32'h0);
        chk({tag, "_hold"}, hold, 1'b0);
        chk({tag, "_ovf"}, ovf, 1'b0);
    endtask

    initial begin
        logic [15:0] p;
        bit          c;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Stream with out_ready high: two-cycle latency, then one entry per cycle.
        for (int i = 0; i < 12; i++) begin
            if (i == 1) chk("lat_not_yet", out_valid, 1'b0);
            if (i >= 2) begin
                chk("lat_valid", out_valid, 1'b1);
                chk("stream_pc", out_pc, 16'(i - 2));
                chk("stream_inst", out_inst, 32'(i - 2) + 32'h100);
            end
            chk("stream_hold", hold, 1'b0);
            cyc(1'b1, 16'(i), 1'b0, 1'b1);
        end
        repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Backpressure with hold honoured: exactly 0x20..0x23 get queued.
        p = 16'h20;
        repeat (8) begin
            c = !hold_m();
            cyc(c, p, 1'b0, 1'b0);
            if (c) p++;
        end
        chk("bp_hold", hold, 1'b1);
        chk("bp_head_pc", out_pc, 16'h20);
        chk("bp_head_inst", out_inst, 32'h120);
        chk("bp_ovf", ovf, 1'b0);
        chk("bp_next_pc", 64'(p), 64'h24);
        repeat (6) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bp_hold_fall", hold, 1'b0);
        chk("bp_drained", out_valid, 1'b0);

        // Flush with three queued and one read in flight, then restart at 0x40.
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'h30 + 16'(k), 1'b0, 1'b0);
        chk("fl_pre_valid", out_valid, 1'b1);
        cyc(1'b1, 16'h99, 1'b1, 1'b0);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_hold", hold, 1'b0);
        cyc(1'b1, 16'h40, 1'b0, 1'b1);
        cyc(1'b1, 16'h41, 1'b0, 1'b1);
        chk("fl_restart_pc", out_pc, 16'h40);
        chk("fl_restart_inst", out_inst, 32'h140);
        repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Full FIFO with forced push alongside pop each cycle.
        p = 16'h50;
        repeat (8) begin
            c = !hold_m();
            cyc(c, p, 1'b0, 1'b0);
            if (c) p++;
        end
        cyc(1'b1, p, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) cyc(1'b1, p + 16'(k), 1'b0, 1'b1);
        chk("pp_head", out_pc, 16'h55);
        chk("pp_hold", hold, 1'b1);
        chk("pp_ovf", ovf, 1'b0);
        repeat (6) cyc(1'b0, 16'h0, 1'b0, 1'b1);

        // Protocol violation: push into a full FIFO.
        for (int k = 0; k < 6; k++) cyc(1'b1, 16'h60 + 16'(k), 1'b0, 1'b0);
        chk("ov_set", ovf, 1'b1);
        chk("ov_head", out_pc, 16'h60);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("ov_after_flush", ovf, 1'b1);
        chk("ov_flush_valid", out_valid, 1'b0);

        // Async reset between clock edges.
        for (int k = 0; k < 3; k++) cyc(1'b1, 16'h70 + 16'(k), 1'b0, 1'b0);
        chk("ar_pre_valid", out_valid, 1'b1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        ce = 1'b0;
        flush = 1'b0;
        last_pc = '0;
        @(negedge clk);
        rst = 1'b1;

        // Random traffic, mostly honouring hold.
        repeat (400) begin
            salt = 16'($urandom);
            if ($urandom_range(0, 19) == 0) c = 1'b1;
            else c = !hold_m() && ($urandom_range(0, 3) != 0);
            cyc(c, 16'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
